// File: rtl/vga_pkg.sv
// vga_pkg: pixel type, text geometry, renderer states and the built-in glyph
// pattern shared by the VGA text path.
package vga_pkg;
  typedef struct packed {
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
  } pixel_t;
  localparam int TEXT_COLS = 80;
  localparam int TEXT_ROWS = 30;
  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 16;
  typedef enum logic {CLEAR, IDLE} rstate_t;
  // Glyph row for address {char, line}; a deterministic pattern so every code and line differ
  function automatic logic [7:0] font_row(input logic [11:0] a);
    return a[11:4] ^ {a[3:0], ~a[3:0]};
  endfunction
endpackage

// File: rtl/vga_font_rom.sv
// vga_font_rom: 4096x8 glyph ROM addressed by {char, line}; one glyph row
// is returned one clock after the address.
module vga_font_rom
  import vga_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] i_addr,
  output logic [7:0]  o_data
);
  always_ff @(posedge clock or posedge reset)
    if (reset) o_data <= '0;
    else o_data <= font_row(i_addr);
endmodule

// File: rtl/vga_text_renderer.sv
// vga_text_renderer: 80x30 character-mode pixel source for the VGA timing
// controller, with host write port, blinking underline cursor and clear engine.
module vga_text_renderer
  import vga_pkg::*;
#(
  parameter int         COLS         = TEXT_COLS,
  parameter int         ROWS         = TEXT_ROWS,
  parameter int         BLINK_FRAMES = 30,
  parameter logic [7:0] CLEAR_CHAR   = 8'h20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [9:0]  x_address,
  input  logic [9:0]  y_address,
  input  logic        blank,
  output pixel_t      data,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [6:0]  wr_col,
  input  logic [4:0]  wr_row,
  input  logic [7:0]  wr_char,
  output logic        wr_error,
  input  logic        clear_req,
  output logic        busy,
  input  logic        cursor_en,
  input  logic [6:0]  cursor_col,
  input  logic [4:0]  cursor_row,
  input  pixel_t      fg_color,
  input  pixel_t      bg_color
);
  localparam int DEPTH = COLS * ROWS;
  localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  rstate_t r_state, w_state_nxt;
  logic [11:0] r_clr_addr, w_clr_nxt, w_wr_addr, w_host_addr, r_rd_addr;
  logic [7:0] w_wr_data, r_char, w_font_row;
  logic w_we, w_accept, w_oor;
  logic [6:0] w_col;
  logic [5:0] w_row;
  logic [3:0] w_line, r_line1, r_line2;
  logic [2:0] r_bit1, r_bit2, r_bit3;
  logic r_blank1, r_blank2, r_blank3, r_cur1, r_cur2, r_cur3;
  logic [BW-1:0] r_blink_cnt;
  logic r_blink_off, w_frame_start, w_blink_wrap, w_pix;
  logic [7:0] r_text [DEPTH];
  assign w_host_addr = 12'({wr_row, 6'b0}) + 12'({wr_row, 4'b0}) + 12'(wr_col);
  assign w_oor = (wr_col >= 7'(COLS)) | (wr_row >= 5'(ROWS));
  assign w_accept = wr_valid & wr_ready;
  // clear_req wins over a same-cycle host write by dropping wr_ready
  always_comb begin
    w_state_nxt = r_state;
    w_clr_nxt = r_clr_addr;
    busy = 1'b0;
    wr_ready = 1'b0;
    w_we = 1'b0;
    w_wr_addr = w_host_addr;
    w_wr_data = wr_char;
    if (r_state == CLEAR) begin
      busy = 1'b1;
      w_we = 1'b1;
      w_wr_addr = r_clr_addr;
      w_wr_data = CLEAR_CHAR;
      w_clr_nxt = clear_req ? '0 : r_clr_addr + 12'd1;
      if (!clear_req && r_clr_addr == 12'(DEPTH - 1)) w_state_nxt = IDLE;
    end else begin
      wr_ready = ~clear_req;
      w_we = wr_valid & ~clear_req & ~w_oor;
      if (clear_req) begin
        w_state_nxt = CLEAR;
        w_clr_nxt = '0;
      end
    end
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_state <= CLEAR;
      r_clr_addr <= '0;
      wr_error <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_clr_addr <= w_clr_nxt;
      wr_error <= w_accept & w_oor;
    end
  always_ff @(posedge clock)
    if (w_we) r_text[w_wr_addr] <= w_wr_data;
  assign w_col = 7'(x_address / GLYPH_W);
  assign w_row = 6'(y_address / GLYPH_H);
  assign w_line = 4'(y_address % GLYPH_H);
  assign w_frame_start = blank & ~r_blank1 & (x_address == '0) & (y_address == '0);
  assign w_blink_wrap = r_blink_cnt == BW'(BLINK_FRAMES - 1);
  // row*80 built as row*64 + row*16 to avoid a multiplier
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_rd_addr <= '0;
      r_line1 <= '0;
      r_bit1 <= '0;
      r_blank1 <= 1'b0;
      r_cur1 <= 1'b0;
      r_char <= '0;
      r_line2 <= '0;
      r_bit2 <= '0;
      r_blank2 <= 1'b0;
      r_cur2 <= 1'b0;
      r_bit3 <= '0;
      r_blank3 <= 1'b0;
      r_cur3 <= 1'b0;
      r_blink_cnt <= '0;
      r_blink_off <= 1'b0;
    end else begin
      r_rd_addr <= 12'({w_row, 6'b0}) + 12'({w_row, 4'b0}) + 12'(w_col);
      r_line1 <= w_line;
      r_bit1 <= 3'(x_address % GLYPH_W);
      r_blank1 <= blank;
      r_cur1 <= (w_col == cursor_col) & (w_row == {1'b0, cursor_row}) & (w_line >= 4'(GLYPH_H - 2));
      r_char <= r_text[r_rd_addr];
      r_line2 <= r_line1;
      r_bit2 <= r_bit1;
      r_blank2 <= r_blank1;
      r_cur2 <= r_cur1;
      r_bit3 <= r_bit2;
      r_blank3 <= r_blank2;
      r_cur3 <= r_cur2;
      if (w_frame_start) begin
        r_blink_cnt <= w_blink_wrap ? '0 : r_blink_cnt + 1'b1;
        r_blink_off <= w_blink_wrap ? ~r_blink_off : r_blink_off;
      end
    end
  vga_font_rom u_font (
    .clock  (clock),
    .reset  (reset),
    .i_addr ({r_char, r_line2}),
    .o_data (w_font_row)
  );
  assign w_pix = w_font_row[3'd7 - r_bit3] ^ (cursor_en & r_cur3 & ~r_blink_off);
  assign data = r_blank3 ? (w_pix ? fg_color : bg_color) : '0;
endmodule

// File: tb/tb_vga_text_renderer.sv
// tb_vga_text_renderer: self-checking bench for the text renderer: clear timing,
// host writes, glyph rendering, cursor blink and clear restart.
module tb_vga_text_renderer;
  import vga_pkg::*;
  localparam int BF = 2;
  logic clock = 1'b0, reset = 1'b1;
  logic [9:0] x_address = '0, y_address = '0;
  logic blank = 1'b0, wr_valid = 1'b0, clear_req = 1'b0, cursor_en = 1'b0;
  logic [6:0] wr_col = '0, cursor_col = '0;
  logic [4:0] wr_row = '0, cursor_row = '0;
  logic [7:0] wr_char = '0;
  pixel_t data, fg_color, bg_color;
  logic wr_ready, wr_error, busy;
  always #5 clock = ~clock;
  vga_text_renderer #(.BLINK_FRAMES(BF)) dut (
    .clock(clock), .reset(reset), .x_address(x_address), .y_address(y_address),
    .blank(blank), .data(data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_col(wr_col), .wr_row(wr_row), .wr_char(wr_char), .wr_error(wr_error),
    .clear_req(clear_req), .busy(busy), .cursor_en(cursor_en),
    .cursor_col(cursor_col), .cursor_row(cursor_row),
    .fg_color(fg_color), .bg_color(bg_color)
  );
  typedef struct { logic [11:0] exp; logic [9:0] x, y; } exp_t;
  typedef struct { logic [6:0] col; logic [4:0] row; logic [7:0] ch; logic err; } wvec_t;
  exp_t sb[$];
  wvec_t wv[7];
  logic [7:0] tm [2400];
  int checks = 0, errors = 0;
  int blink_cnt = 0;
  logic blink_vis = 1'b1, prev_blank = 1'b0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [11:0] model_px(input logic [9:0] x, input logic [9:0] y, input logic b);
    int col = int'(x) / 8;
    int row = int'(y) / 16;
    logic [3:0] ln = y[3:0];
    logic [7:0] ch, g;
    logic p;
    if (!b) return 12'h0;
    ch = (row < 30 && col < 80) ? tm[row * 80 + col] : 8'h20;
    g = ch ^ {ln, ~ln};
    p = g[7 - int'(x[2:0])];
    if (cursor_en && col == int'(cursor_col) && row == int'(cursor_row) && ln >= 4'd14 && blink_vis) p = ~p;
    return p ? fg_color : bg_color;
  endfunction
  task automatic pop_chk();
    exp_t e = sb.pop_front();
    chk($sformatf("pixel x=%0d y=%0d", e.x, e.y), 32'(data), 32'(e.exp));
  endtask
  task automatic step_px(input int x, input int y, input logic b);
    exp_t e;
    @(negedge clock);
    if (sb.size() == 3) pop_chk();
    if (b && !prev_blank && x == 0 && y == 0) begin
      if (blink_cnt == BF - 1) begin
        blink_cnt = 0;
        blink_vis = ~blink_vis;
      end else blink_cnt++;
    end
    prev_blank = b;
    x_address = 10'(x);
    y_address = 10'(y);
    blank = b;
    e.exp = model_px(x_address, y_address, b);
    e.x = x_address;
    e.y = y_address;
    sb.push_back(e);
  endtask
  task automatic drain();
    while (sb.size() > 0) begin
      @(negedge clock);
      pop_chk();
    end
  endtask
  task automatic render_cell(input int c, input int r, input int l0, input int l1);
    for (int l = l0; l <= l1; l++)
      for (int b = 0; b < 8; b++) step_px(c * 8 + b, r * 16 + l, 1'b1);
    step_px(0, 0, 1'b0);
  endtask
  task automatic host_write(input wvec_t v);
    @(negedge clock);
    wr_valid = 1'b1;
    wr_col = v.col;
    wr_row = v.row;
    wr_char = v.ch;
    #1 chk($sformatf("wr_ready col=%0d row=%0d", v.col, v.row), 32'(wr_ready), 32'd1);
    @(negedge clock);
    wr_valid = 1'b0;
    chk($sformatf("wr_error col=%0d row=%0d", v.col, v.row), 32'(wr_error), 32'(v.err));
    @(negedge clock);
    chk("wr_error one cycle", 32'(wr_error), 32'd0);
    if (v.col < 80 && v.row < 30) tm[int'(v.row) * 80 + int'(v.col)] = v.ch;
  endtask
  task automatic count_busy(input string nm);
    int n = 0, rdy = 0;
    while (busy && n < 3000) begin
      if (wr_ready) rdy++;
      n++;
      @(negedge clock);
    end
    chk({nm, " busy cycles"}, 32'(n), 32'd2400);
    chk({nm, " wr_ready while busy"}, 32'(rdy), 32'd0);
    chk({nm, " wr_ready after clear"}, 32'(wr_ready), 32'd1);
  endtask
  initial begin
    fg_color = pixel_t'(12'hF80);
    bg_color = pixel_t'(12'h024);
    wv[0] = '{7'd0,   5'd0,  8'h41, 1'b0};
    wv[1] = '{7'd79,  5'd29, 8'h5A, 1'b0};
    wv[2] = '{7'd80,  5'd0,  8'h42, 1'b1};
    wv[3] = '{7'd5,   5'd2,  8'h43, 1'b0};
    wv[4] = '{7'd0,   5'd30, 8'h44, 1'b1};
    wv[5] = '{7'd127, 5'd31, 8'h45, 1'b1};
    wv[6] = '{7'd10,  5'd1,  8'h7E, 1'b0};
    for (int i = 0; i < 2400; i++) tm[i] = 8'h20;
    #12;
    chk("reset busy", 32'(busy), 32'd1);
    chk("reset wr_ready", 32'(wr_ready), 32'd0);
    chk("reset wr_error", 32'(wr_error), 32'd0);
    chk("reset data", 32'(data), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    count_busy("initial clear");
    render_cell(3, 4, 0, 15);
    drain();
    for (int i = 0; i < 7; i++) host_write(wv[i]);
    render_cell(0, 0, 0, 15);
    render_cell(79, 29, 13, 15);
    render_cell(0, 1, 0, 3);
    render_cell(5, 2, 12, 15);
    render_cell(10, 1, 0, 1);
    drain();
    for (int i = 0; i < 8; i++) step_px(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1'b0);
    drain();
    cursor_col = 7'd5;
    cursor_row = 5'd2;
    cursor_en = 1'b1;
    for (int f = 0; f < 5; f++) begin
      step_px(0, 0, 1'b0);
      if (f > 0) step_px(0, 0, 1'b1);
      step_px(0, 0, 1'b0);
      render_cell(5, 2, 13, 15);
      drain();
    end
    cursor_en = 1'b0;
    @(negedge clock);
    clear_req = 1'b1;
    wr_valid = 1'b1;
    wr_col = 7'd1;
    wr_row = 5'd0;
    wr_char = 8'h5A;
    #1 chk("wr_ready dropped by clear_req", 32'(wr_ready), 32'd0);
    @(negedge clock);
    clear_req = 1'b0;
    wr_valid = 1'b0;
    chk("busy after clear_req", 32'(busy), 32'd1);
    repeat (999) @(negedge clock);
    clear_req = 1'b1;
    @(negedge clock);
    clear_req = 1'b0;
    count_busy("restarted clear");
    for (int i = 0; i < 2400; i++) tm[i] = 8'h20;
    render_cell(0, 0, 0, 3);
    render_cell(1, 0, 0, 1);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
